// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types, constants and helpers for the ASCON-128 encrypt core
package ascon_pack;

    // Five 64-bit state words; x0 is the most significant field so that
    // {IV, K_hi, K_lo, N_hi, N_lo} maps directly onto x0..x4.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    localparam logic [63:0] ASCON_IV = 64'h80400C0600000000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_AD,
        AD_PERM,
        WAIT_DATA,
        DATA_PERM,
        FINAL,
        DONE
    } state_t;

    // Round constant for round index r: F0, E1, D2, ... 4B.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return 8'hF0 - ({4'h0, r} * 8'h0F);
    endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational ASCON permutation round
module ascon_round
    import ascon_pack::*;
(
    input  type_state   s_in,
    input  logic [3:0]  rnd,
    output type_state   s_out
);

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    // Constant addition, bitsliced 5-bit S-box, then per-word linear diffusion.
    always_comb begin
        x0 = s_in.x0;
        x1 = s_in.x1;
        x2 = s_in.x2 ^ {56'h0, round_const(rnd)};
        x3 = s_in.x3;
        x4 = s_in.x4;

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        s_out.x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        s_out.x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        s_out.x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        s_out.x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        s_out.x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    end

endmodule

// File: rtl/ascon_encrypt_top.sv
// rtl/ascon_encrypt_top.sv - ASCON-128 encrypt core (1 AD word, 3 data words); ASCON_ENC_UNROLL2_EN selects two rounds per cycle
module ascon_encrypt_top
    import ascon_pack::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          data_valid_i,
    input  logic [63:0]   data_i,
    input  logic [127:0]  key_i,
    input  logic [127:0]  nonce_i,
    output logic          ready_o,
    output logic          cipher_valid_o,
    output logic [63:0]   cipher_o,
    output logic          end_o,
    output logic [127:0]  tag_o
);

    state_t     state;
    type_state  s;
    logic [3:0] rnd;
    logic [1:0] blk;
    type_state  r1_out;
    type_state  perm_out;

    ascon_round u_round0 (
        .s_in  (s),
        .rnd   (rnd),
        .s_out (r1_out)
    );

`ifdef ASCON_ENC_UNROLL2_EN
    localparam logic [3:0] RND_STEP = 4'd2;

    ascon_round u_round1 (
        .s_in  (r1_out),
        .rnd   (rnd + 4'd1),
        .s_out (perm_out)
    );
`else
    localparam logic [3:0] RND_STEP = 4'd1;

    assign perm_out = r1_out;
`endif

    // Round index at which the current cycle completes round 11.
    localparam logic [3:0] RND_LAST = 4'd12 - RND_STEP;

    // Control FSM, state register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            s              <= '0;
            rnd            <= '0;
            blk            <= '0;
            ready_o        <= 1'b0;
            cipher_valid_o <= 1'b0;
            cipher_o       <= '0;
            end_o          <= 1'b0;
            tag_o          <= '0;
        end else begin
            cipher_valid_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        s     <= {ASCON_IV, key_i, nonce_i};
                        rnd   <= '0;
                        blk   <= '0;
                        end_o <= 1'b0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    s <= perm_out;
                    if (rnd == RND_LAST) begin
                        s.x3    <= perm_out.x3 ^ key_i[127:64];
                        s.x4    <= perm_out.x4 ^ key_i[63:0];
                        ready_o <= 1'b1;
                        state   <= WAIT_AD;
                    end else begin
                        rnd <= rnd + RND_STEP;
                    end
                end
                WAIT_AD: begin
                    if (data_valid_i) begin
                        s.x0    <= s.x0 ^ data_i;
                        rnd     <= 4'd6;
                        ready_o <= 1'b0;
                        state   <= AD_PERM;
                    end
                end
                AD_PERM: begin
                    s <= perm_out;
                    if (rnd == RND_LAST) begin
                        s.x4    <= perm_out.x4 ^ 64'd1;
                        ready_o <= 1'b1;
                        state   <= WAIT_DATA;
                    end else begin
                        rnd <= rnd + RND_STEP;
                    end
                end
                WAIT_DATA: begin
                    if (data_valid_i) begin
                        s.x0           <= s.x0 ^ data_i;
                        cipher_o       <= s.x0 ^ data_i;
                        cipher_valid_o <= 1'b1;
                        ready_o        <= 1'b0;
                        if (blk == 2'd2) begin
                            s.x1  <= s.x1 ^ key_i[127:64];
                            s.x2  <= s.x2 ^ key_i[63:0];
                            rnd   <= '0;
                            state <= FINAL;
                        end else begin
                            blk   <= blk + 2'd1;
                            rnd   <= 4'd6;
                            state <= DATA_PERM;
                        end
                    end
                end
                DATA_PERM: begin
                    s <= perm_out;
                    if (rnd == RND_LAST) begin
                        ready_o <= 1'b1;
                        state   <= WAIT_DATA;
                    end else begin
                        rnd <= rnd + RND_STEP;
                    end
                end
                FINAL: begin
                    s <= perm_out;
                    if (rnd == RND_LAST) begin
                        tag_o <= {perm_out.x3 ^ key_i[127:64], perm_out.x4 ^ key_i[63:0]};
                        end_o <= 1'b1;
                        state <= DONE;
                    end else begin
                        rnd <= rnd + RND_STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_encrypt_top.sv
// tb/tb_ascon_encrypt_top.sv - randomized self-checking bench for ascon_encrypt_top against an ASCON-128 reference
module tb_ascon_encrypt_top;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dv;
    logic [63:0]   data;
    logic [127:0]  key;
    logic [127:0]  nonce;
    logic          ready;
    logic          cv;
    logic [63:0]   cipher;
    logic          endo;
    logic [127:0]  tag;

    ascon_encrypt_top dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .data_valid_i   (dv),
        .data_i         (data),
        .key_i          (key),
        .nonce_i        (nonce),
        .ready_o        (ready),
        .cipher_valid_o (cv),
        .cipher_o       (cipher),
        .end_o          (endo),
        .tag_o          (tag)
    );

    always #5 clk = ~clk;

`ifdef ASCON_ENC_UNROLL2_EN
    localparam int P12 = 6;
    localparam int P6  = 3;
`else
    localparam int P12 = 12;
    localparam int P6  = 6;
`endif
    // Cycles from the start_i cycle to the first DONE cycle, both counted.
    localparam int END_LAT = 1 + P12 + 1 + P6 + 3 + 2 * P6 + P12 + 1;
    // Cycle (counted from the start cycle) that lands mid-way through FINAL.
    localparam int RST_CYC = 5 + P12 + 3 * P6 + P12 / 2 - 1;

    localparam logic [159:0] SBOX_TBL = {
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Reference model: state as five words, S-box applied column by column via table.
    logic [63:0] m_s [5];
    logic [63:0] e_c [3];
    logic [127:0] e_tag;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic m_perm(input int first);
        logic [63:0] nw [5];
        logic [4:0]  idx;
        logic [4:0]  o;
        for (int r = first; r < 12; r++) begin
            m_s[2] = m_s[2] ^ 64'((240 - r * 15) & 255);
            for (int j = 0; j < 64; j++) begin
                idx = {m_s[0][j], m_s[1][j], m_s[2][j], m_s[3][j], m_s[4][j]};
                o = SBOX_TBL[159 - 5 * int'(idx) -: 5];
                nw[0][j] = o[4];
                nw[1][j] = o[3];
                nw[2][j] = o[2];
                nw[3][j] = o[1];
                nw[4][j] = o[0];
            end
            m_s[0] = nw[0] ^ ror(nw[0], 19) ^ ror(nw[0], 28);
            m_s[1] = nw[1] ^ ror(nw[1], 61) ^ ror(nw[1], 39);
            m_s[2] = nw[2] ^ ror(nw[2], 1)  ^ ror(nw[2], 6);
            m_s[3] = nw[3] ^ ror(nw[3], 10) ^ ror(nw[3], 17);
            m_s[4] = nw[4] ^ ror(nw[4], 7)  ^ ror(nw[4], 41);
        end
    endtask

    task automatic m_ref(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                         input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
        logic [63:0] p [3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        m_s[0] = 64'h80400C0600000000;
        m_s[1] = k[127:64]; m_s[2] = k[63:0];
        m_s[3] = n[127:64]; m_s[4] = n[63:0];
        m_perm(0);
        m_s[3] ^= k[127:64]; m_s[4] ^= k[63:0];
        m_s[0] ^= ad;
        m_perm(6);
        m_s[4] ^= 64'd1;
        for (int i = 0; i < 3; i++) begin
            m_s[0] ^= p[i];
            e_c[i] = m_s[0];
            if (i < 2) m_perm(6);
        end
        m_s[1] ^= k[127:64]; m_s[2] ^= k[63:0];
        m_perm(0);
        e_tag = {m_s[3] ^ k[127:64], m_s[4] ^ k[63:0]};
    endtask

    // Observations of one run.
    logic [63:0]  r_c [3];
    int           r_ncv, r_lat;
    logic         r_timeout, r_end_first, r_stall_ok, r_rst_hit;
    logic [127:0] r_tag_first;
    logic [127:0] r_rz_tag;
    logic [63:0]  r_rz_cipher;
    logic [2:0]   r_rz_flags;

    task automatic run(input logic [127:0] k, input logic [127:0] n, input logic [63:0] ad,
                       input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2,
                       input int stall, input bit glitch, input int rst_at);
        logic [63:0] words [4];
        int wi, cyc, stalled;
        bit done;
        words[0] = ad; words[1] = p0; words[2] = p1; words[3] = p2;
        wi = 0; cyc = 0; stalled = 0; done = 0;
        r_ncv = 0; r_lat = -1; r_timeout = 1'b0; r_stall_ok = 1'b1; r_rst_hit = 1'b0;
        r_c[0] = '0; r_c[1] = '0; r_c[2] = '0;
        @(negedge clk);
        key = k; nonce = n; start = 1'b1; dv = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (glitch && cyc == 3);
            nonce = (glitch && cyc == 3) ? ~n : n;
            if (cyc == 1) begin
                r_end_first = endo;
                r_tag_first = tag;
            end
            if (cv) begin
                if (r_ncv < 3) r_c[r_ncv] = cipher;
                r_ncv++;
            end
            if (endo) begin
                r_lat = cyc + 1;
                done = 1;
            end else if (rst_at == cyc) begin
                rst = 1'b1; dv = 1'b0; start = 1'b1;
                @(posedge clk);
                #1;
                r_rst_hit   = 1'b1;
                r_rz_tag    = tag;
                r_rz_cipher = cipher;
                r_rz_flags  = {ready, cv, endo};
                rst = 1'b0; start = 1'b0;
                done = 1;
            end else begin
                dv = 1'b0;
                if (wi == 1 && stalled > 0 && stalled < stall && !ready) r_stall_ok = 1'b0;
                if (ready && wi < 4) begin
                    if (wi == 1 && stalled < stall) begin
                        stalled++;
                    end else begin
                        dv = 1'b1; data = words[wi]; wi++;
                    end
                end else if (glitch && !ready && (wi == 2 || wi == 3)) begin
                    dv = 1'b1; data = {$urandom, $urandom};
                end
            end
        end
        dv = 1'b0; start = 1'b0;
        if (!done) r_timeout = 1'b1;
    endtask

    task automatic check_result(input string pfx, input int extra_lat);
        chk({pfx, "_timeout"}, 128'(r_timeout), 128'd0);
        chk({pfx, "_c0"}, 128'(r_c[0]), 128'(e_c[0]));
        chk({pfx, "_c1"}, 128'(r_c[1]), 128'(e_c[1]));
        chk({pfx, "_c2"}, 128'(r_c[2]), 128'(e_c[2]));
        chk({pfx, "_ncv"}, 128'(r_ncv), 128'd3);
        chk({pfx, "_tag"}, tag, e_tag);
        chk({pfx, "_lat"}, 128'(r_lat), 128'(END_LAT + extra_lat));
    endtask

    logic [127:0] k0, n0, n1, kr, nr, prev_tag;
    logic [63:0]  ad0, pa, pb, pc, adr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dv = 1'b0; data = '0; key = '0; nonce = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready), 128'd0);
        chk("rst_cv", 128'(cv), 128'd0);
        chk("rst_end", 128'(endo), 128'd0);
        chk("rst_cipher", 128'(cipher), 128'd0);
        chk("rst_tag", tag, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known key/nonce/AD, random plaintext.
        k0  = 128'h000102030405060708090A0B0C0D0E0F;
        n0  = 128'h000102030405060708090A0B0C0D0E0F;
        ad0 = 64'h3230323280000000;
        pa = {$urandom, $urandom}; pb = {$urandom, $urandom}; pc = {$urandom, $urandom};
        m_ref(k0, n0, ad0, pa, pb, pc);
        run(k0, n0, ad0, pa, pb, pc, 0, 1'b0, -1);
        chk("base_end_first", 128'(r_end_first), 128'd0);
        check_result("base", 0);

        // Restart straight from DONE with a new nonce.
        prev_tag = e_tag;
        n1 = {$urandom, $urandom, $urandom, $urandom};
        m_ref(k0, n1, ad0, pa, pb, pc);
        run(k0, n1, ad0, pa, pb, pc, 0, 1'b0, -1);
        chk("restart_end_falls", 128'(r_end_first), 128'd0);
        chk("restart_tag_held", r_tag_first, prev_tag);
        check_result("restart", 0);

        // 20-cycle stall in WAIT_DATA.
        m_ref(k0, n0, ad0, pa, pb, pc);
        run(k0, n0, ad0, pa, pb, pc, 20, 1'b0, -1);
        chk("stall_ready_held", 128'(r_stall_ok), 128'd1);
        check_result("stall", 20);

        // Spurious start during INIT and data_valid during DATA_PERM.
        run(k0, n0, ad0, pa, pb, pc, 0, 1'b1, -1);
        check_result("glitch", 0);

        // Reset in the middle of FINAL, then the same run again.
        run(k0, n0, ad0, pa, pb, pc, 0, 1'b0, RST_CYC);
        chk("midrst_hit", 128'(r_rst_hit), 128'd1);
        chk("midrst_tag", r_rz_tag, 128'd0);
        chk("midrst_cipher", 128'(r_rz_cipher), 128'd0);
        chk("midrst_flags", 128'(r_rz_flags), 128'd0);
        run(k0, n0, ad0, pa, pb, pc, 0, 1'b0, -1);
        check_result("after_rst", 0);

        // Fully random vectors.
        for (int i = 0; i < 4; i++) begin
            kr  = {$urandom, $urandom, $urandom, $urandom};
            nr  = {$urandom, $urandom, $urandom, $urandom};
            adr = {$urandom, $urandom};
            pa = {$urandom, $urandom}; pb = {$urandom, $urandom}; pc = {$urandom, $urandom};
            m_ref(kr, nr, adr, pa, pb, pc);
            run(kr, nr, adr, pa, pb, pc, (i == 2) ? 3 : 0, 1'b0, -1);
            check_result("rand", (i == 2) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
